// File: rtl/card_dealer.sv
// card_dealer: pseudo-random card source feeding the hand evaluator.
// Deals two opening cards on a deal press, one more card per hit press
// (four cards maximum), and empties the hand when the evaluator reports
// the round finished. An all-zero hand means "no hand" downstream.
module card_dealer #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,  // must be nonzero
    parameter int         CARD_MAX  = 10      // cards span 1..CARD_MAX, CARD_MAX <= 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       deal,
    input  logic       hit,
    input  logic       round_done,
    output logic [3:0] first_card,
    output logic [3:0] second_card,
    output logic [3:0] third_card,
    output logic [3:0] fourth_card,
    output logic [2:0] card_count,
    output logic       hand_active
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DEAL_A = 3'd1;
    localparam logic [2:0] S_DEAL_B = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_FULL   = 3'd4;

    logic [7:0] r_lfsr;
    logic       r_deal_prev;
    logic       r_hit_prev;
    logic [2:0] r_state;
    logic [2:0] r_count;
    logic       r_active;

    logic       w_deal_rise;
    logic       w_hit_rise;
    logic       w_feedback;
    logic [3:0] w_draw;
    logic [3:0] w_draw_tab [16];
    logic [2:0] w_state_next;
    logic [2:0] w_count_next;
    logic [3:0] w_load;
    logic       w_clear;

    assign w_deal_rise = deal & ~r_deal_prev;
    assign w_hit_rise  = hit  & ~r_hit_prev;
    assign w_feedback  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Constant lookup of (n mod CARD_MAX) + 1 for every 4-bit n; never yields 0.
    for (genvar gi = 0; gi < 16; gi++) begin : g_draw
        localparam int CARD_VAL = (gi % CARD_MAX) + 1;
        assign w_draw_tab[gi] = 4'(CARD_VAL);
    end

    assign w_draw = w_draw_tab[r_lfsr[3:0]];

    // Free-running Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifts every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    // Button history; reset to 1 so a button held through reset gives no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deal_prev <= 1'b1;
            r_hit_prev  <= 1'b1;
        end else begin
            r_deal_prev <= deal;
            r_hit_prev  <= hit;
        end
    end

    // Next-state, slot-load and clear decisions for the dealing sequence.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_load       = 4'b0000;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_deal_rise) begin
                    w_state_next = S_DEAL_A;
                end
            end
            S_DEAL_A: begin
                w_load[0]    = 1'b1;
                w_count_next = 3'd1;
                w_state_next = S_DEAL_B;
            end
            S_DEAL_B: begin
                w_load[1]    = 1'b1;
                w_count_next = 3'd2;
                w_state_next = S_PLAY;
            end
            S_PLAY: begin
                // round_done wins over a hit arriving in the same cycle
                if (round_done) begin
                    w_clear      = 1'b1;
                    w_count_next = 3'd0;
                    w_state_next = S_IDLE;
                end else if (w_hit_rise) begin
                    w_load[r_count[1:0]] = 1'b1;
                    w_count_next         = r_count + 3'd1;
                    if (r_count == 3'd3) begin
                        w_state_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (round_done) begin
                    w_clear      = 1'b1;
                    w_count_next = 3'd0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_count_next = 3'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, card count and registered hand_active flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= 3'd0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_active <= (w_state_next == S_PLAY) || (w_state_next == S_FULL);
        end
    end

    // One register per card slot: loaded once by its deal step, held until cleared.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        logic [3:0] r_slot;

        // Slot load / clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_slot <= 4'd0;
            end else if (w_clear) begin
                r_slot <= 4'd0;
            end else if (w_load[gi]) begin
                r_slot <= w_draw;
            end
        end
    end

    assign first_card  = g_slot[0].r_slot;
    assign second_card = g_slot[1].r_slot;
    assign third_card  = g_slot[2].r_slot;
    assign fourth_card = g_slot[3].r_slot;
    assign card_count  = r_count;
    assign hand_active = r_active;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: table-driven check of card_dealer with hand-computed
// LFSR-derived card values, plus an asynchronous mid-deal reset sequence.
module tb_card_dealer;

    logic       clk;
    logic       rst;
    logic       deal;
    logic       hit;
    logic       round_done;
    logic [3:0] first_card;
    logic [3:0] second_card;
    logic [3:0] third_card;
    logic [3:0] fourth_card;
    logic [2:0] card_count;
    logic       hand_active;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       d;
        logic       h;
        logic       rd;
        logic [3:0] c0;
        logic [3:0] c1;
        logic [3:0] c2;
        logic [3:0] c3;
        logic [2:0] cnt;
        logic       act;
    } vec_t;

    localparam int NVEC = 34;
    vec_t tbl [NVEC];

    card_dealer dut (
        .clk         (clk),
        .rst         (rst),
        .deal        (deal),
        .hit         (hit),
        .round_done  (round_done),
        .first_card  (first_card),
        .second_card (second_card),
        .third_card  (third_card),
        .fourth_card (fourth_card),
        .card_count  (card_count),
        .hand_active (hand_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic d, input logic h, input logic rd,
                                input logic [3:0] c0, input logic [3:0] c1,
                                input logic [3:0] c2, input logic [3:0] c3,
                                input logic [2:0] cnt, input logic act);
        vec_t v;
        v.d = d; v.h = h; v.rd = rd;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
        v.cnt = cnt; v.act = act;
        return v;
    endfunction

    task automatic chk(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, tag, act, exp);
        end
    endtask

    task automatic chk_outputs(input string name, input int tag, input vec_t v);
        chk({name, ".first"},  tag, {4'd0, first_card},  {4'd0, v.c0});
        chk({name, ".second"}, tag, {4'd0, second_card}, {4'd0, v.c1});
        chk({name, ".third"},  tag, {4'd0, third_card},  {4'd0, v.c2});
        chk({name, ".fourth"}, tag, {4'd0, fourth_card}, {4'd0, v.c3});
        chk({name, ".count"},  tag, {5'd0, card_count},  {5'd0, v.cnt});
        chk({name, ".active"}, tag, {7'd0, hand_active}, {7'd0, v.act});
    endtask

    // Apply rows lo..hi, one clock each; outputs sampled 1 time unit after the edge.
    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            deal       = tbl[r].d;
            hit        = tbl[r].h;
            round_done = tbl[r].rd;
            @(posedge clk);
            #1;
            $display("row %0d: deal=%0b hit=%0b rd=%0b -> cards %0d %0d %0d %0d count=%0d active=%0b",
                     r, tbl[r].d, tbl[r].h, tbl[r].rd, first_card, second_card,
                     third_card, fourth_card, card_count, hand_active);
            chk_outputs("row", r, tbl[r]);
        end
    endtask

    // Reset with both buttons held high, released on a falling edge.
    task automatic do_reset();
        deal       = 1'b1;
        hit        = 1'b1;
        round_done = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t zero_v;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        deal  = 1'b1;
        hit   = 1'b1;
        round_done = 1'b0;
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Row r is sampled at edge r+1 after reset release. Card drawn at edge e
        // uses LFSR state s(e-1): s13=DD->4, s14=BB->2, s16=EC->3, s20=CF->6,
        // s27=BF->6, s28=7E->5, s29=FD->4.
        for (int r = 0; r < 10; r++) tbl[r] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0); // held buttons: no edge
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);  // hit edge in IDLE ignored
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);  // deal edge -> DEAL_A
        tbl[13] = mk(0, 0, 0, 4, 0, 0, 0, 1, 0);  // first card
        tbl[14] = mk(0, 0, 0, 4, 2, 0, 0, 2, 1);  // second card, PLAY
        tbl[15] = mk(1, 0, 0, 4, 2, 0, 0, 2, 1);  // deal edge in PLAY ignored
        tbl[16] = mk(0, 1, 0, 4, 2, 3, 0, 3, 1);  // hit -> third card
        tbl[17] = mk(0, 1, 0, 4, 2, 3, 0, 3, 1);  // sustained hit: no extra card
        tbl[18] = mk(0, 1, 0, 4, 2, 3, 0, 3, 1);
        tbl[19] = mk(0, 0, 0, 4, 2, 3, 0, 3, 1);
        tbl[20] = mk(0, 1, 0, 4, 2, 3, 6, 4, 1);  // hit -> fourth card, FULL
        tbl[21] = mk(0, 0, 0, 4, 2, 3, 6, 4, 1);
        tbl[22] = mk(0, 1, 0, 4, 2, 3, 6, 4, 1);  // hit in FULL ignored
        tbl[23] = mk(1, 0, 0, 4, 2, 3, 6, 4, 1);  // deal in FULL ignored
        tbl[24] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);  // round_done clears
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);  // second hand
        tbl[27] = mk(0, 0, 0, 6, 0, 0, 0, 1, 0);
        tbl[28] = mk(0, 0, 0, 6, 5, 0, 0, 2, 1);
        tbl[29] = mk(0, 1, 0, 6, 5, 4, 0, 3, 1);
        tbl[30] = mk(0, 0, 0, 6, 5, 4, 0, 3, 1);
        tbl[31] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);  // round_done beats same-cycle hit
        tbl[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[33] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);  // round_done in IDLE ignored

        // Reset values while reset is asserted.
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("in_reset", 0, zero_v);

        do_reset();
        run_rows(0, NVEC - 1);

        // Mid-deal asynchronous reset: stop in DEAL_B (first card dealt).
        do_reset();
        run_rows(0, 13);
        #2;
        rst = 1'b1;
        #1;  // still well before the next rising edge
        $display("async reset in DEAL_B: cards %0d %0d %0d %0d count=%0d active=%0b",
                 first_card, second_card, third_card, fourth_card, card_count, hand_active);
        chk_outputs("async_rst", 0, zero_v);

        // After release the LFSR restarts at the seed: same cards as before.
        deal = 1'b1;
        hit  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_rows(0, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
